mem_port_arbiter: RTL and testbench

- Shares one single-port unified instruction/data memory between the Fetch stage (instruction port) and the Memory stage (data port) of the 5-stage pipeline.
- Decides each cycle which requester owns the memory port. Tracks the one outstanding access and routes read data back to its owner.
- Drives stall_if. The Hazard_Unit ORs stall_if into its StallF/StallD terms.
- The data port normally wins, because it carries the older instruction. A starvation guard ensures fetch always makes progress.

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_port_arbiter_if.sv | 41 ++++
 rtl/mem_port_arbiter_lat_tracker.sv | 60 ++++++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    localparam int MEM_LAT_MAX = 4;
    localparam int STARVE_W    = 8;
    localparam int LAT_W       = $clog2(MEM_LAT_MAX + 1);

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory-side signal bundle of the arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [DATA_W/8-1:0]   d_be;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_W-1:0]     d_rdata;

    logic                  mem_en;
    logic                  mem_we;
    logic [DATA_W/8-1:0]   mem_be;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;

    logic                  stall_if;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata, stall_if
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata, stall_if
    );
endinterface

// File: rtl/mem_port_arbiter_lat_tracker.sv
// rtl/mem_port_arbiter_lat_tracker.sv - outstanding-read tracker: owner, latency countdown, rvalid
module mem_arb_lat_tracker
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   issue_rd_i,
    input  owner_e issue_owner_i,
    output logic   port_free_o,
    output logic   rvalid_if_o,
    output logic   rvalid_d_o
);

    arb_state_e       state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    owner_e           owner_q, owner_d;
    logic             complete;

    assign complete = (state_q == ARB_BUSY) && (lat_q == LAT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            lat_q   <= '0;
            owner_q <= OWN_NONE;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        owner_d = owner_q;
        if (state_q == ARB_BUSY) begin
            if (complete) begin
                state_d = ARB_IDLE;
                lat_d   = '0;
                owner_d = OWN_NONE;
            end else begin
                lat_d = lat_q - 1'b1;
            end
        end
        // A new read may be issued in the completion cycle, overriding the return to IDLE.
        if (issue_rd_i) begin
            state_d = ARB_BUSY;
            lat_d   = LAT_W'(MEM_LAT);
            owner_d = issue_owner_i;
        end
    end

    assign port_free_o = (state_q == ARB_IDLE) || complete;
    assign rvalid_if_o = complete && (owner_q == OWN_IF) && !rst;
    assign rvalid_d_o  = complete && (owner_q == OWN_D) && !rst;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a shared single-port memory
// Optional MEM_ARB_PERF_CNT_EN adds conflict and fetch-wait performance counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]      perf_conflict_cnt,
    output logic [31:0]      perf_if_wait_cnt
`endif
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic                port_free;
    logic                free;
    logic                starved;
    logic                gnt_if;
    logic                gnt_d;
    logic                issue_rd;
    owner_e              issue_owner;
    logic                rvalid_if;
    logic                rvalid_d;
    logic                stall_if;
    logic [STARVE_W-1:0] starve_q, starve_d;

    assign free    = port_free && !rst;
    assign starved = (starve_q == STARVE_LIM);

    // Data normally wins as the older instruction; a saturated starvation count flips priority.
    always_comb begin
        gnt_if = 1'b0;
        gnt_d  = 1'b0;
        if (free) begin
            if (starved && bus.if_req) begin
                gnt_if = 1'b1;
            end else if (bus.d_req) begin
                gnt_d = 1'b1;
            end else if (bus.if_req) begin
                gnt_if = 1'b1;
            end
        end
    end

    assign issue_rd    = gnt_if || (gnt_d && !bus.d_we);
    assign issue_owner = gnt_if ? OWN_IF : OWN_D;
    assign stall_if    = bus.if_req && !gnt_if && !rst;

    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_be    = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (gnt_if) begin
            bus.mem_en   = 1'b1;
            bus.mem_be   = {BE_W{1'b1}};
            bus.mem_addr = bus.if_addr;
        end else if (gnt_d) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.d_we;
            bus.mem_be    = bus.d_be;
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
        end
    end

    always_comb begin
        starve_d = '0;
        if (bus.if_req && !gnt_if) begin
            starve_d = starved ? starve_q : starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    mem_arb_lat_tracker #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_tracker (
        .clk           (clk),
        .rst           (rst),
        .issue_rd_i    (issue_rd),
        .issue_owner_i (issue_owner),
        .port_free_o   (port_free),
        .rvalid_if_o   (rvalid_if),
        .rvalid_d_o    (rvalid_d)
    );

    assign bus.if_gnt    = gnt_if;
    assign bus.d_gnt     = gnt_d;
    assign bus.if_rvalid = rvalid_if;
    assign bus.d_rvalid  = rvalid_d;
    assign bus.if_rdata  = rvalid_if ? bus.mem_rdata : '0;
    assign bus.d_rdata   = rvalid_d ? bus.mem_rdata : '0;
    assign bus.stall_if  = stall_if;

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] conflict_q, conflict_d;
    logic [31:0] if_wait_q, if_wait_d;

    always_comb begin
        conflict_d = conflict_q;
        if_wait_d  = if_wait_q;
        if (free && bus.if_req && bus.d_req) begin
            conflict_d = conflict_q + 32'd1;
        end
        if (stall_if) begin
            if_wait_d = if_wait_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_q <= '0;
            if_wait_q  <= '0;
        end else begin
            conflict_q <= conflict_d;
            if_wait_q  <= if_wait_d;
        end
    end

    assign perf_conflict_cnt = conflict_q;
    assign perf_if_wait_cnt  = if_wait_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int LAT  = 2;
    localparam int SMAX = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] perf_conf;
    logic [31:0] perf_wait;
`endif

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .MEM_LAT    (LAT),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef MEM_ARB_PERF_CNT_EN
        ,
        .perf_conflict_cnt (perf_conf),
        .perf_if_wait_cnt  (perf_wait)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory environment: applies writes, returns read data LAT cycles after issue.
    logic [31:0] env_mem [256];
    logic [31:0] rd_pipe [LAT];
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we)
            for (int b = 0; b < 4; b++)
                if (bus.mem_be[b]) env_mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? env_mem[bus.mem_addr[9:2]] : $urandom;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.mem_rdata = rd_pipe[LAT-1];

    // Reference model: port free from cycle next_free on; waited counts denied fetch cycles.
    logic [31:0] ref_mem [256];
    typedef struct {
        bit          is_if;
        logic [31:0] data;
        int          due;
    } rsp_t;
    rsp_t sb[$];
    int next_free = 0;
    int waited    = 0;
    int exp_conf  = 0;
    int exp_wait  = 0;
    bit g_if_last, g_d_last;
    bit if_pend, d_pend;

    initial begin
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = '0;
            ref_mem[i] = '0;
        end
        for (int i = 0; i < LAT; i++) rd_pipe[i] = '0;
    end

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_timeout(string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // Called right after inputs are driven at negedge: predicts and checks this cycle.
    task automatic step();
        bit free, prio, g_if, g_d;
        logic [31:0] w;
        #1;
        g_if_last = 1'b0;
        g_d_last  = 1'b0;
        if (rst) begin
            chk("reset_out_a", {bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.d_gnt, bus.d_rvalid,
                                bus.d_rdata, bus.stall_if}, '0);
            chk("reset_out_b", {bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata}, '0);
            sb.delete();
            next_free = cyc + 1;
            waited    = 0;
            exp_conf  = 0;
            exp_wait  = 0;
            return;
        end
        free = (cyc >= next_free);
        prio = (waited == SMAX);
        g_if = free && bus.if_req && (prio || !bus.d_req);
        g_d  = free && bus.d_req && !g_if;
        chk("grant", {bus.if_gnt, bus.d_gnt, bus.mem_en, bus.stall_if},
            {g_if, g_d, g_if || g_d, bus.if_req && !g_if});
        if (g_if) begin
            chk("fetch_issue", {bus.mem_we, bus.mem_be, bus.mem_addr}, {1'b0, 4'hF, bus.if_addr});
            sb.push_back('{is_if: 1'b1, data: ref_mem[bus.if_addr[9:2]], due: cyc + LAT});
            next_free = cyc + LAT;
        end else if (g_d) begin
            chk("data_issue", {bus.mem_we, bus.mem_be, bus.mem_addr}, {bus.d_we, bus.d_be, bus.d_addr});
            if (bus.d_we) begin
                chk("data_wdata", bus.mem_wdata, bus.d_wdata);
                w = ref_mem[bus.d_addr[9:2]];
                for (int b = 0; b < 4; b++)
                    if (bus.d_be[b]) w[8*b +: 8] = bus.d_wdata[8*b +: 8];
                ref_mem[bus.d_addr[9:2]] = w;
                next_free = cyc + 1;
            end else begin
                sb.push_back('{is_if: 1'b0, data: ref_mem[bus.d_addr[9:2]], due: cyc + LAT});
                next_free = cyc + LAT;
            end
        end
        if (free && bus.if_req && bus.d_req) exp_conf++;
        if (bus.if_req && !g_if) begin
            exp_wait++;
            waited = (waited < SMAX) ? waited + 1 : SMAX;
        end else begin
            waited = 0;
        end
        g_if_last = g_if;
        g_d_last  = g_d;
    endtask

    // Response monitor: pops the scoreboard whenever the DUT presents rvalid.
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            #2;
            if (rst) continue;
            if (bus.if_rvalid || bus.d_rvalid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rvalid: if=%b d=%b (cycle %0d)", bus.if_rvalid, bus.d_rvalid, cyc);
                end else begin
                    r = sb.pop_front();
                    chk("rsp_owner_time", {bus.if_rvalid, bus.d_rvalid, cyc}, {r.is_if, !r.is_if, r.due});
                    chk("rsp_data", r.is_if ? {bus.if_rdata, bus.d_rdata} : {bus.d_rdata, bus.if_rdata},
                        {r.data, 32'h0});
                end
            end else begin
                if (sb.size() != 0 && sb[0].due <= cyc) begin
                    r = sb.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_rvalid: got none expected %s response due cycle %0d (cycle %0d)",
                             r.is_if ? "fetch" : "data", r.due, cyc);
                end
                chk("idle_rdata", {bus.if_rdata, bus.d_rdata}, '0);
            end
        end
    end

    task automatic idle_cycle();
        @(negedge clk);
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        step();
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            idle_cycle();
            n++;
        end
        if (sb.size() != 0) fail_timeout("drain");
        idle_cycle();
        idle_cycle();
    endtask

    task automatic do_req(bit is_if, bit we, logic [3:0] be, logic [31:0] addr, logic [31:0] wdata);
        int n = 0;
        @(negedge clk);
        if (is_if) begin
            bus.if_req  = 1'b1;
            bus.if_addr = addr;
        end else begin
            bus.d_req   = 1'b1;
            bus.d_we    = we;
            bus.d_be    = be;
            bus.d_addr  = addr;
            bus.d_wdata = wdata;
        end
        step();
        while (!(is_if ? g_if_last : g_d_last)) begin
            if (++n > 50) begin
                fail_timeout("do_req_grant");
                break;
            end
            @(negedge clk);
            step();
        end
    endtask

    task automatic rand_cycle(int p_if, int p_d, int p_flush);
        bit fl_if = 1'b0, fl_d = 1'b0;
        @(negedge clk);
        if (if_pend && $urandom_range(99) < p_flush) begin if_pend = 1'b0; fl_if = 1'b1; end
        if (d_pend && $urandom_range(99) < p_flush) begin d_pend = 1'b0; fl_d = 1'b1; end
        if (!if_pend && !fl_if && $urandom_range(99) < p_if) begin
            if_pend     = 1'b1;
            bus.if_addr = 32'($urandom_range(255)) << 2;
        end
        if (!d_pend && !fl_d && $urandom_range(99) < p_d) begin
            d_pend      = 1'b1;
            bus.d_we    = 1'($urandom_range(1));
            bus.d_be    = 4'($urandom_range(1, 15));
            bus.d_addr  = 32'($urandom_range(255)) << 2;
            bus.d_wdata = $urandom;
        end
        bus.if_req = if_pend;
        bus.d_req  = d_pend;
        step();
        if (g_if_last) if_pend = 1'b0;
        if (g_d_last) d_pend = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, first;
        bit found;
        bus.if_req = 1'b1; bus.if_addr = 32'h4;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 32'h8; bus.d_wdata = '0;

        // Reset with both requests pending: everything must stay quiet.
        @(negedge clk); rst = 1'b1; step();
        @(negedge clk); step();
        @(negedge clk); rst = 1'b0; bus.if_req = 1'b0; bus.d_req = 1'b0; step();

        // Partial write then read-back of the same word.
        do_req(1'b0, 1'b1, 4'b0011, 32'h200, 32'hDEADBEEF);
        do_req(1'b0, 1'b0, 4'hF, 32'h200, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            idle_cycle();
            if (bus.d_rvalid) begin
                found = 1'b1;
                chk("readback_0x200", bus.d_rdata, 32'h0000BEEF);
            end
        end
        if (!found) fail_timeout("readback_0x200");
        drain();

        // Fetch-only stream.
        do_req(1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
        do_req(1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
        do_req(1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
        drain();

        // Simultaneous fetch and data read: data wins, fetch waits out the latency.
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 32'h100;
        step();
        chk("simul_data_wins", {bus.d_gnt, bus.if_gnt}, 2'b10);
        n = 0;
        found = 1'b0;
        while (!found && n < 20) begin
            @(negedge clk);
            bus.d_req = 1'b0;
            step();
            n++;
            found = bus.if_gnt;
        end
        chk("simul_fetch_delay", 32'(n), 32'(LAT));
        drain();

        // Saturated data traffic: fetch must break through after SMAX denied cycles.
        if_pend = 1'b0; d_pend = 1'b0;
        first = -1;
        for (int i = 0; i < 80; i++) begin
            rand_cycle(100, 100, 0);
            if (bus.if_gnt && first < 0) first = i;
        end
        chk("starve_first_fetch", 32'(first), 32'(SMAX));
        if_pend = 1'b0; d_pend = 1'b0;
        drain();

        // Random traffic with flushes.
        for (int i = 0; i < 3000; i++) rand_cycle(50, 50, 8);
        if_pend = 1'b0; d_pend = 1'b0;
        drain();

        // Reset one cycle after a fetch issue: the read must never complete.
        do_req(1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
        @(negedge clk); rst = 1'b1; bus.if_req = 1'b0; step();
        @(negedge clk); rst = 1'b0; step();
        for (int i = 0; i < 6; i++) idle_cycle();
        @(negedge clk); bus.if_req = 1'b1; bus.if_addr = 32'h44; step();
        chk("post_reset_grant", bus.if_gnt, 1'b1);
        drain();

`ifdef MEM_ARB_PERF_CNT_EN
        @(negedge clk);
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        #1;
        chk("perf_conflict", perf_conf, 32'(exp_conf));
        chk("perf_if_wait", perf_wait, 32'(exp_wait));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
